// File: rtl/mem_ctrl.sv
// Byte-addressable big-endian data memory with valid/ready request/response and configurable read latency.
// Optional: define MEM_CTRL_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module mem_ctrl #(
    parameter int MEM_DEPTH  = 250000,
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [7:0] mem [MEM_DEPTH];

    logic             accept, fault, range_flt, misalign, wr_en;
    logic [2:0]       nbytes_m1;
    logic [ADDR_W:0]  last_addr;
    logic [ADDR_W:0]  addr_k [4];
    logic [IDX_W-1:0] idx    [4];
    logic [7:0]       rbyte  [4];
    logic [7:0]       wbyte  [4];
    logic [31:0]      wshift, load_data;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;

    always_comb begin
        case (req_size)
            2'b00:   nbytes_m1 = 3'd0;
            2'b01:   nbytes_m1 = 3'd1;
            default: nbytes_m1 = 3'd3;
        endcase
    end

    // One extra address bit so a request near the top of the address space cannot wrap into range.
    assign last_addr = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, nbytes_m1};
    assign range_flt = (req_size == 2'b11) || (last_addr > (ADDR_W+1)'(MEM_DEPTH - 1));

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault = range_flt || misalign;
    assign wr_en = accept && !req_rw && !fault;

    // Left-align store data so byte k of the access is always wshift[31-8k -: 8].
    always_comb begin
        case (req_size)
            2'b00:   wshift = {req_wdata[7:0], 24'h0};
            2'b01:   wshift = {req_wdata[15:0], 16'h0};
            default: wshift = req_wdata;
        endcase
    end

    // Out-of-range byte lanes are clamped to 0; their data is never used because the access faults.
    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign addr_k[k] = {1'b0, req_addr} + (ADDR_W+1)'(k);
        assign idx[k]    = (addr_k[k] < (ADDR_W+1)'(MEM_DEPTH)) ? addr_k[k][IDX_W-1:0] : '0;
        assign rbyte[k]  = mem[idx[k]];
        assign wbyte[k]  = wshift[31-8*k -: 8];
    end

    always_comb begin
        case (req_size)
            2'b00:   load_data = {{24{req_signed & rbyte[0][7]}}, rbyte[0]};
            2'b01:   load_data = {{16{req_signed & rbyte[0][7]}}, rbyte[0], rbyte[1]};
            default: load_data = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[idx[0]] <= wbyte[0];
            if (req_size != 2'b00) mem[idx[1]] <= wbyte[1];
            if (req_size == 2'b10) begin
                mem[idx[2]] <= wbyte[2];
                mem[idx[3]] <= wbyte[3];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d   = fault;
                    rdata_d = (req_rw && !fault) ? load_data : 32'h0;
                    if (!req_rw || RD_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(RD_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed steps plus random accesses checked against a byte-map reference model.
module tb_mem_ctrl;
    localparam int DEPTH = 250000;
    localparam int AW    = 32;
    localparam int RDL   = 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_rw = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    always #5 clock = ~clock;

    mem_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_W(AW), .RD_LATENCY(RDL)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0]  model_mem [longint];
    logic [31:0] last_rd;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: memory is a sparse byte map; loads are assembled as base-256 numbers.
    task automatic ref_model(input bit rw, input bit [1:0] size, input bit sgn, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output bit err,
                             output bit known, output int lat);
        int n;
        longint v;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || (longint'(a) + n - 1 > longint'(DEPTH) - 1);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        if ((size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0)) err = 1'b1;
`endif
        lat   = rw ? RDL : 1;
        rd    = 32'h0;
        known = 1'b1;
        if (!err && !rw)
            for (int k = 0; k < n; k++) model_mem[longint'(a) + k] = 8'(wd >> (8 * (n - 1 - k)));
        if (!err && rw) begin
            v = 0;
            for (int k = 0; k < n; k++) begin
                if (!model_mem.exists(longint'(a) + k)) known = 1'b0;
                else v = v * 256 + longint'(model_mem[longint'(a) + k]);
            end
            if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
            rd = 32'(v);
        end
    endtask

    task automatic do_access(input bit rw, input bit [1:0] size, input bit sgn, input logic [31:0] a,
                             input logic [31:0] wd, output int lat);
        @(negedge clock);
        req_valid = 1'b1; req_rw = rw; req_size = size; req_signed = sgn;
        req_addr = a; req_wdata = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
        last_rd  = resp_rdata;
        last_err = resp_err;
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input bit rw, input bit [1:0] size, input bit sgn,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] erd;
        bit eerr, known;
        int elat, lat;
        ref_model(rw, size, sgn, a, wd, erd, eerr, known, elat);
        do_access(rw, size, sgn, a, wd, lat);
        chk($sformatf("%s lat", tag), 32'(lat), 32'(elat));
        chk($sformatf("%s err", tag), {31'h0, last_err}, {31'h0, eerr});
        if (known) chk($sformatf("%s rdata", tag), last_rd, erd);
    endtask

    initial begin
        #(200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit saw_resp;
        #2 reset_n = 1'b0;
        #1;
        chk("rst req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err", {31'h0, resp_err}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Word write then latency-3 word read
        run("t1 wr", 1'b0, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
        run("t1 rd", 1'b1, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("t1 data", last_rd, 32'hDEADBEEF);

        run("t2 rb s", 1'b1, 2'd0, 1'b1, 32'h101, 32'h0);
        chk("t2 rb s data", last_rd, 32'hFFFFFFAD);
        run("t2 rb u", 1'b1, 2'd0, 1'b0, 32'h101, 32'h0);
        chk("t2 rb u data", last_rd, 32'h000000AD);
        run("t2 rh s", 1'b1, 2'd1, 1'b1, 32'h102, 32'h0);
        chk("t2 rh s data", last_rd, 32'hFFFFBEEF);

        run("t3 wb", 1'b0, 2'd0, 1'b0, 32'h103, 32'hFFFFFF55);
        run("t3 rd", 1'b1, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("t3 data", last_rd, 32'hDEADBE55);

        // Top-of-memory boundary and faults
        run("t4 wb0", 1'b0, 2'd0, 1'b0, DEPTH - 2, 32'hA1);
        run("t4 wb1", 1'b0, 2'd0, 1'b0, DEPTH - 1, 32'hA2);
        run("t4 ww flt", 1'b0, 2'd2, 1'b0, DEPTH - 2, 32'h12345678);
        chk("t4 ww err", {31'h0, last_err}, 32'd1);
        chk("t4 ww rdata", last_rd, 32'h0);
        run("t4 rh top", 1'b1, 2'd1, 1'b0, DEPTH - 2, 32'h0);
        chk("t4 rh top data", last_rd, 32'h0000A1A2);
        run("t4 rb past", 1'b1, 2'd0, 1'b0, DEPTH, 32'h0);
        run("t4 rsv", 1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
        chk("t4 rsv err", {31'h0, last_err}, 32'd1);
        run("t4 wrap", 1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);

        // Response stall with a competing request held on req_valid
        @(negedge clock);
        req_valid = 1'b1; req_rw = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h100;
        @(posedge clock);
        #1 req_rw = 1'b0; req_wdata = 32'h11;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
        chk("t5 lat", 32'(lat), 32'(RDL));
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("t5 hold%0d valid", i), {31'h0, resp_valid}, 32'd1);
            chk($sformatf("t5 hold%0d rdata", i), resp_rdata, 32'h000000DE);
            chk($sformatf("t5 hold%0d ready", i), {31'h0, req_ready}, 32'd0);
        end
        @(negedge clock);
        resp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        chk("t5 rel valid", {31'h0, resp_valid}, 32'd0);
        chk("t5 rel ready", {31'h0, req_ready}, 32'd1);
        run("t5 noacc", 1'b1, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("t5 noacc data", last_rd, 32'hDEADBE55);

        // Reset while a read is in WAIT
        @(negedge clock);
        req_valid = 1'b1; req_rw = 1'b1; req_size = 2'd2; req_addr = 32'h100;
        @(posedge clock);
        #1 req_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("t6 rst valid", {31'h0, resp_valid}, 32'd0);
        chk("t6 rst ready", {31'h0, req_ready}, 32'd1);
        chk("t6 rst rdata", resp_rdata, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        saw_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1 if (resp_valid) saw_resp = 1'b1;
        end
        chk("t6 no resp", {31'h0, saw_resp}, 32'd0);

        // A write survives a reset taken while its response is pending
        @(negedge clock);
        req_valid = 1'b1; req_rw = 1'b0; req_size = 2'd0; req_addr = 32'h300; req_wdata = 32'h77;
        @(posedge clock);
        #1 req_valid = 1'b0;
        chk("t6 wr valid", {31'h0, resp_valid}, 32'd1);
        reset_n = 1'b0;
        #1 chk("t6 wr rst valid", {31'h0, resp_valid}, 32'd0);
        model_mem[longint'(32'h300)] = 8'h77;
        @(negedge clock);
        reset_n = 1'b1;
        run("t6 keep", 1'b1, 2'd0, 1'b0, 32'h300, 32'h0);

        run("t6 align", 1'b1, 2'd2, 1'b0, 32'h101, 32'h0);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        chk("t6 align err", {31'h0, last_err}, 32'd1);
`else
        chk("t6 align err", {31'h0, last_err}, 32'd0);
`endif

        // Random traffic: fill a window, then mixed accesses inside it and near the top
        for (int k = 0; k < 16; k++) run($sformatf("init%0d", k), 1'b0, 2'd2, 1'b0, 32'h200 + 32'(4 * k), $urandom);
        for (int i = 0; i < 80; i++) begin
            int r, n;
            bit [1:0] sz;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            sz = (r == 7) ? 2'd3 : 2'($urandom_range(0, 2));
            n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            if (r < 8) a = 32'h200 + 32'($urandom_range(0, 64 - n));
            else if (r == 8) a = DEPTH - 32'($urandom_range(0, 4));
            else a = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
